// File: rtl/cnn_layer_accel_weight_sequence_ctrl.sv
// Weight-sequence controller: walks rows x columns x C_SEQ_LEN table entries per pass.
// Optional stalled-cycle counter enabled by CNN_LAYER_ACCEL_WSEQ_STALL_STATS_EN.
module cnn_layer_accel_weight_sequence_ctrl #(
    parameter int C_SEQ_LEN = 5,
    parameter int C_ROW_W   = 10,
    parameter int C_COL_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [C_ROW_W-1:0] cfg_num_rows,
    input  logic [C_COL_W-1:0] cfg_num_cols,
    input  logic               stall,
    output logic [1:0]         gray_code,
    output logic               sequence_selector,
    output logic [2:0]         seq_data_addr,
    output logic               seq_valid,
    output logic               wht_addr_valid,
    output logic               busy,
    output logic               done
`ifdef CNN_LAYER_ACCEL_WSEQ_STALL_STATS_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [2:0] LAST_ADDR = 3'(C_SEQ_LEN - 1);

    state_t             state_r;
    logic [C_ROW_W-1:0] rows_r;
    logic [C_COL_W-1:0] cols_r;
    logic [C_ROW_W-1:0] row_r;
    logic [C_COL_W-1:0] col_r;
    logic [2:0]         addr_r;
    logic [1:0]         gray_r;
    logic               sel_r;
    logic               last_addr_s;
    logic               last_col_s;
    logic               last_row_s;
    logic               cfg_ok_s;

    function automatic logic [1:0] gray_next(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            2'b10:   n = 2'b00;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // End-of-entry / column / row detection for the issue pointer.
    always_comb begin
        last_addr_s = (addr_r == LAST_ADDR);
        last_col_s  = ((col_r + C_COL_W'(1)) == cols_r);
        last_row_s  = ((row_r + C_ROW_W'(1)) == rows_r);
        cfg_ok_s    = (cfg_num_rows != '0) && (cfg_num_cols != '0);
    end

    // Sequencing FSM; the pointer registers hold the next entry, outputs show the issued one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= ST_IDLE;
            rows_r            <= '0;
            cols_r            <= '0;
            row_r             <= '0;
            col_r             <= '0;
            addr_r            <= 3'd0;
            gray_r            <= 2'b00;
            sel_r             <= 1'b1;
            gray_code         <= 2'b00;
            sequence_selector <= 1'b1;
            seq_data_addr     <= 3'd0;
            seq_valid         <= 1'b0;
            wht_addr_valid    <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
`ifdef CNN_LAYER_ACCEL_WSEQ_STALL_STATS_EN
            stall_cycles      <= 16'd0;
`endif
        end else begin
            wht_addr_valid <= seq_valid;
            done           <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    seq_valid <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
`ifdef CNN_LAYER_ACCEL_WSEQ_STALL_STATS_EN
                        stall_cycles <= 16'd0;
`endif
                        if (cfg_ok_s) begin
                            rows_r  <= cfg_num_rows;
                            cols_r  <= cfg_num_cols;
                            row_r   <= '0;
                            col_r   <= '0;
                            addr_r  <= 3'd0;
                            gray_r  <= 2'b00;
                            sel_r   <= 1'b1;
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stall) begin
                        seq_valid <= 1'b0;
`ifdef CNN_LAYER_ACCEL_WSEQ_STALL_STATS_EN
                        if (stall_cycles != 16'hFFFF) begin
                            stall_cycles <= stall_cycles + 16'd1;
                        end else begin
                            stall_cycles <= stall_cycles;
                        end
`endif
                    end else begin
                        seq_valid         <= 1'b1;
                        seq_data_addr     <= addr_r;
                        gray_code         <= gray_r;
                        sequence_selector <= sel_r;
                        if (last_addr_s) begin
                            addr_r <= 3'd0;
                            if (last_col_s) begin
                                col_r  <= '0;
                                sel_r  <= 1'b1;
                                gray_r <= gray_next(gray_r);
                                if (last_row_s) begin
                                    row_r   <= '0;
                                    state_r <= ST_DRAIN;
                                end else begin
                                    row_r <= row_r + C_ROW_W'(1);
                                end
                            end else begin
                                col_r <= col_r + C_COL_W'(1);
                                sel_r <= ~sel_r;
                            end
                        end else begin
                            addr_r <= addr_r + 3'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    seq_valid <= 1'b0;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    seq_valid <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    seq_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cnn_layer_accel_weight_sequence_ctrl.md
CNN_LAYER_ACCEL_WEIGHT_SEQUENCE_CTRL -- requirements
Module: cnn_layer_accel_weight_sequence_ctrl

Interface
REQ-001 Parameter C_SEQ_LEN, default 5, meaning weight-sequence entries per kernel window; range 2..8.
REQ-002 Parameter C_ROW_W, default 10, meaning width of the row count.
REQ-003 Parameter C_COL_W, default 10, meaning width of the column count.
REQ-004 Port clk  in  1  the single clock; all logic is rising-edge.
REQ-005 Port rst  in  1  asynchronous, active-low reset.
REQ-006 Port start  in  1  one-cycle pulse requesting a pass; sampled only in IDLE.
REQ-007 Port cfg_num_rows  in  C_ROW_W  output rows per pass; captured on an accepted start.
REQ-008 Port cfg_num_cols  in  C_COL_W  kernel windows per row; captured on an accepted start.
REQ-009 Port stall  in  1  downstream hold; freezes sequencing while high.
REQ-010 Port gray_code  out  2  row phase for the weight sequence table.
REQ-011 Port sequence_selector  out  1  column-parity select for the table.
REQ-012 Port seq_data_addr  out  3  table entry index.
REQ-013 Port seq_valid  out  1  gray_code, sequence_selector and seq_data_addr are valid this cycle.
REQ-014 Port wht_addr_valid  out  1  seq_valid delayed one cycle; aligns with the registered table output.
REQ-015 Port busy  out  1  high in every state except IDLE.
REQ-016 Port done  out  1  one-cycle end-of-pass pulse.
REQ-017 Port stall_cycles  out  16  stalled-cycle count; present only with the REQ-033 macro.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE; every output SHALL be registered.
REQ-019 IDLE with start=1 and both cfg counts nonzero SHALL latch the cfg counts and go to RUN; with either count zero it SHALL go to DONE with no seq_valid.
REQ-020 start asserted outside IDLE SHALL be ignored.
REQ-021 In RUN with stall=0, seq_valid SHALL be 1 and seq_data_addr SHALL step 0,1,...,C_SEQ_LEN-1, then wrap to 0.
REQ-022 On each seq_data_addr wrap, the column counter SHALL increment and sequence_selector SHALL toggle.
REQ-023 On the wrap of the last column, the column counter SHALL return to 0, sequence_selector SHALL return to 1 and gray_code SHALL advance 00->01->11->10->00.
REQ-024 Issuing the last entry of the last column of the last row SHALL move RUN to DRAIN; a pass SHALL produce exactly C_SEQ_LEN*rows*cols seq_valid cycles.
REQ-025 In RUN with stall=1, seq_valid SHALL be 0 and all counters and address outputs SHALL hold.
REQ-026 DRAIN SHALL last one cycle with seq_valid=0, then go to DONE.
REQ-027 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-028 wht_addr_valid SHALL equal seq_valid of the previous cycle in every state.
REQ-029 stall SHALL have no effect in IDLE, DRAIN or DONE.

Reset
REQ-030 On rst=0, the block SHALL immediately enter IDLE.
REQ-031 The reset values SHALL be: gray_code=00, sequence_selector=1, seq_data_addr=0, seq_valid=0, wht_addr_valid=0, busy=0, done=0, stall_cycles=0, counters=0.
REQ-032 Reset asserted mid-pass SHALL abandon the pass without a done pulse.

Configuration
REQ-033 With CNN_LAYER_ACCEL_WSEQ_STALL_STATS_EN defined, stall_cycles SHALL count RUN cycles with stall=1, clear on an accepted start, and saturate at 16'hFFFF; without it, the port and counter SHALL be absent and function SHALL be otherwise identical.

Verification
REQ-034 Scenario rows=1, cols=1, start -> seq_data_addr 0..4 on 5 consecutive seq_valid cycles with gray=00 and sel=1; wht_addr_valid on the 5 following-shifted cycles; done 2 cycles after the last seq_valid.
REQ-035 Scenario rows=2, cols=2 -> 20 seq_valid cycles; sel pattern 1,0 per row; gray 00 for the first 10 cycles and 01 for the last 10.
REQ-036 Scenario rows=5, cols=1 -> gray sequence 00,01,11,10,00; 25 seq_valid cycles.
REQ-037 Scenario stall held 3 cycles at seq_data_addr=2 -> 3 cycles with seq_valid=0 and outputs frozen, resumption at addr 3; with the macro, stall_cycles=3.
REQ-038 Scenario rst low during RUN, then start rows=1, cols=1 -> outputs at reset values, no done pulse, then a clean 5-entry pass.
REQ-039 Scenario start with cols=0, plus start pulsed during RUN -> no seq_valid and done one cycle later; the start during RUN is ignored.
